// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Execute-stage resolver for RISC-V control instructions (BEQ/BNE/BLT/BGE/
//   BLTU/BGEU, JAL, JALR). It compares each outcome with the prediction made
//   at fetch, emits a registered predictor update, and on a mispredict runs
//   the redirect/flush handshake with fetch. It also keeps branch and
//   mispredict statistics.
// Ports:
//   clk, rst (sync, active-low)
//   ex_*            : execute-stage instruction, operands and fetch prediction
//   ex_stall        : hold the execute stage (high whenever not IDLE)
//   update_*/actual_*: predictor update, valid for one cycle on update_en
//   redirect_*      : restart request to fetch, held until redirect_ready
//   flush           : kill younger in-flight instructions
//   branch_count, mispredict_count : wrapping performance counters
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic                 ex_is_branch,
    input  logic                 ex_is_jal,
    input  logic                 ex_is_jalr,
    input  logic [2:0]           ex_funct3,
    input  logic [31:0]          ex_pc,
    input  logic [31:0]          ex_rs1,
    input  logic [31:0]          ex_rs2,
    input  logic [31:0]          ex_imm,
    input  logic                 ex_pred_taken,
    input  logic [31:0]          ex_pred_target,
    output logic                 ex_stall,
    output logic                 update_en,
    output logic [31:0]          update_pc,
    output logic [31:0]          actual_target,
    output logic                 actual_taken,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    input  logic                 redirect_ready,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    typedef enum logic [1:0] {IDLE, REDIR, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [3:0]  flush_cnt;

    logic        accept;
    logic        cond;
    logic        taken;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        mispredict;
    logic [31:0] pc_imm;
    logic [31:0] rs1_imm;

    assign pc_imm  = ex_pc + ex_imm;
    assign rs1_imm = ex_rs1 + ex_imm;

    assign ex_stall = (state != IDLE);
    assign accept   = ex_valid & (state == IDLE) & (ex_is_branch | ex_is_jal | ex_is_jalr);

    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:  cond = (ex_rs1 == ex_rs2);
            3'b001:  cond = (ex_rs1 != ex_rs2);
            3'b100:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  cond = (ex_rs1 <  ex_rs2);
            3'b111:  cond = (ex_rs1 >= ex_rs2);
            default: cond = 1'b0;
        endcase
    end

    // JALR outranks JAL, which outranks a conditional branch.
    always_comb begin
        target = pc_imm;
        taken  = cond;
        if (ex_is_jalr) begin
            target = {rs1_imm[31:1], 1'b0};
            taken  = 1'b1;
        end else if (ex_is_jal) begin
            taken  = 1'b1;
        end
    end

    assign next_pc = taken ? target : (ex_pc + 32'd4);

    // A not-taken instruction predicted not-taken is correct whatever the
    // predicted target was; the target only matters when both say taken.
    assign mispredict = (taken != ex_pred_taken) |
                        (taken & ex_pred_taken & (target != ex_pred_target));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            flush_cnt        <= '0;
            update_en        <= 1'b0;
            update_pc        <= '0;
            actual_target    <= '0;
            actual_taken     <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            flush            <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            update_en <= accept;
            if (accept) begin
                update_pc     <= ex_pc;
                actual_target <= target;
                actual_taken  <= taken;
                branch_count  <= branch_count + CNT_WIDTH'(1);
                if (mispredict)
                    mispredict_count <= mispredict_count + CNT_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (accept && mispredict) begin
                        state          <= REDIR;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= next_pc;
                        flush          <= 1'b1;
                    end
                end
                REDIR: begin
                    if (redirect_ready) begin
                        state          <= FLUSH;
                        redirect_valid <= 1'b0;
                        flush_cnt      <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed vectors with hand-computed
// expectations. Updates and redirects are pushed into queues by the
// stimulus and checked by an independent monitor on the falling edge.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm, ex_pred_target;
    logic        ex_pred_taken;
    logic        ex_stall, update_en, actual_taken, redirect_valid, redirect_ready, flush;
    logic [31:0] update_pc, actual_target, redirect_pc;
    logic [31:0] branch_count, mispredict_count;

    branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
        .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_stall(ex_stall), .update_en(update_en), .update_pc(update_pc),
        .actual_target(actual_target), .actual_taken(actual_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .flush(flush),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
    } upd_t;

    upd_t        uq[$];
    logic [31:0] rq[$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected updates / redirects as the DUT presents them.
    logic        prev_rv  = 1'b0;
    logic [31:0] prev_rpc = '0;
    always @(negedge clk) begin
        upd_t e;
        if (update_en === 1'b1) begin
            if (uq.size() == 0) begin
                chk("upd_unexpected", 32'(update_en), 32'd0);
            end else begin
                e = uq.pop_front();
                chk("upd_pc", update_pc, e.pc);
                chk("upd_target", actual_target, e.tgt);
                chk("upd_taken", 32'(actual_taken), 32'(e.taken));
            end
        end
        if (redirect_valid === 1'b1 && !prev_rv) begin
            if (rq.size() == 0)
                chk("redir_unexpected", 32'(redirect_valid), 32'd0);
            else
                chk("redir_pc", redirect_pc, rq.pop_front());
        end else if (redirect_valid === 1'b1 && prev_rv) begin
            chk("redir_pc_stable", redirect_pc, prev_rpc);
        end
        prev_rv  = redirect_valid;
        prev_rpc = redirect_pc;
    end

    // Presents one instruction for one rising edge; caller clears ex_valid.
    task automatic issue(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic pt, input logic [31:0] ptgt,
                         input logic e_taken, input logic [31:0] e_tgt,
                         input logic e_mis, input logic [31:0] e_npc);
        upd_t u;
        @(negedge clk);
        ex_valid = 1'b1; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
        ex_funct3 = f3; ex_pc = pc; ex_rs1 = rs1; ex_rs2 = rs2; ex_imm = imm;
        ex_pred_taken = pt; ex_pred_target = ptgt;
        u.pc = pc; u.tgt = e_tgt; u.taken = e_taken;
        uq.push_back(u);
        if (e_mis) rq.push_back(e_npc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
    endtask

    // Accept the pending redirect and wait (bounded) for IDLE.
    task automatic drain;
        int n;
        n = 0;
        @(negedge clk);
        redirect_ready = 1'b1;
        while (ex_stall === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        redirect_ready = 1'b0;
        chk("drain_timeout", 32'(ex_stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; redirect_ready = 1'b0;
        idle_in();
        ex_funct3 = '0; ex_pc = '0; ex_rs1 = '0; ex_rs2 = '0; ex_imm = '0;
        ex_pred_taken = 1'b0; ex_pred_target = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_update_en", 32'(update_en), 32'd0);
        chk("rst_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_stall", 32'(ex_stall), 32'd0);
        chk("rst_bcount", branch_count, 32'd0);
        chk("rst_mcount", mispredict_count, 32'd0);
        rst = 1'b1;

        // Correct BEQ taken.
        issue(1,0,0,3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1, 32'h120, 1, 32'h120, 0, 0);
        idle_in();
        @(negedge clk);
        chk("beq_redirect", 32'(redirect_valid), 32'd0);
        chk("beq_bcount", branch_count, 32'd1);
        chk("beq_mcount", mispredict_count, 32'd0);

        // BLT direction mispredict (signed: -1 < 1).
        issue(1,0,0,3'b100, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h40, 0, 32'h0, 1, 32'h240, 1, 32'h240);
        // Present an instruction while in REDIR: it must be ignored.
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_funct3 = 3'b000;
        ex_pc = 32'h260; ex_rs1 = 32'd1; ex_rs2 = 32'd2; ex_pred_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("blt_rv_held", 32'(redirect_valid), 32'd1);
            chk("blt_stall", 32'(ex_stall), 32'd1);
            chk("blt_flush", 32'(flush), 32'd1);
        end
        idle_in();
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        chk("blt_rv_drop", 32'(redirect_valid), 32'd0);
        chk("blt_flush1", 32'(flush), 32'd1);
        @(negedge clk);
        chk("blt_flush2", 32'(flush), 32'd1);
        chk("blt_stall2", 32'(ex_stall), 32'd1);
        @(negedge clk);
        chk("blt_flush_end", 32'(flush), 32'd0);
        chk("blt_idle", 32'(ex_stall), 32'd0);
        chk("blt_bcount", branch_count, 32'd2);
        chk("blt_mcount", mispredict_count, 32'd1);

        // BLTU / BGEU back to back with same operands (unsigned: big > 1).
        issue(1,0,0,3'b110, 32'h300, 32'hFFFFFFFF, 32'd1, 32'h10, 0, 32'h0,   0, 32'h310, 0, 0);
        issue(1,0,0,3'b111, 32'h304, 32'hFFFFFFFF, 32'd1, 32'h10, 1, 32'h314, 1, 32'h314, 0, 0);
        idle_in();
        @(negedge clk);
        chk("unsigned_redirect", 32'(redirect_valid), 32'd0);
        chk("unsigned_bcount", branch_count, 32'd4);

        // JALR target mispredict: (0x1003+0) & ~1 = 0x1002.
        issue(0,0,1,3'b000, 32'h400, 32'h1003, 32'd0, 32'h0, 1, 32'h1000, 1, 32'h1002, 1, 32'h1002);
        idle_in();
        drain();
        chk("jalr_mcount", mispredict_count, 32'd2);

        // BNE not taken at the top of memory: next PC wraps to 0.
        issue(1,0,0,3'b001, 32'hFFFFFFFC, 32'd7, 32'd7, 32'h8, 1, 32'h4, 0, 32'h4, 1, 32'h0);
        idle_in();
        drain();

        // JAL backwards, correct; JAL+JALR flags -> JALR wins; funct3 010 not taken.
        issue(0,1,0,3'b000, 32'h500, 32'h0, 32'h0, 32'hFFFFFF00, 1, 32'h400, 1, 32'h400, 0, 0);
        issue(1,1,1,3'b000, 32'h600, 32'h2000, 32'h0, 32'h4, 1, 32'h2004, 1, 32'h2004, 0, 0);
        issue(1,0,0,3'b010, 32'h700, 32'd1, 32'd1, 32'h8, 0, 32'h0, 0, 32'h708, 0, 0);
        idle_in();
        @(negedge clk);
        chk("mix_bcount", branch_count, 32'd9);
        chk("mix_mcount", mispredict_count, 32'd3);

        // BEQ predicted taken but not taken; reset in the middle of FLUSH.
        issue(1,0,0,3'b000, 32'h800, 32'd1, 32'd2, 32'h10, 1, 32'h900, 0, 32'h810, 1, 32'h804);
        idle_in();
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        chk("pre_rst_flush", 32'(flush), 32'd1);
        chk("pre_rst_bcount", branch_count, 32'd10);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_flush", 32'(flush), 32'd0);
        chk("mid_rst_stall", 32'(ex_stall), 32'd0);
        chk("mid_rst_bcount", branch_count, 32'd0);
        chk("mid_rst_mcount", mispredict_count, 32'd0);

        // Works again after reset.
        issue(1,0,0,3'b101, 32'h900, 32'd3, 32'hFFFFFFFE, 32'h8, 1, 32'h908, 1, 32'h908, 0, 0);
        idle_in();
        repeat (2) @(negedge clk);
        chk("post_rst_bcount", branch_count, 32'd1);
        chk("uq_empty", 32'(uq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
